// File: rtl/sr_cmd_sequencer.sv
// Command sequencer for a downstream SR flip-flop: queues set/reset/toggle/hold
// commands, drives s/r for the requested length, then checks the fed-back state.
module sr_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_op,
    input  logic [LEN_W-1:0]            cmd_len,
    input  logic                        q,
    output logic                        s,
    output logic                        r,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    input  logic                        err_clr,
    output logic [7:0]                  err_cnt,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_RESET  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE
    } state_t;

    logic [LEN_W+1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;

    state_t           state_q;
    logic [LEN_W-1:0] cnt_q;
    logic             s_q;
    logic             r_q;
    logic             exp_q;
    logic             done_q;
    logic             err_q;
    logic [7:0]       err_cnt_q;
    logic [7:0]       err_cnt_d;

    logic             push;
    logic             pop;
    logic [LEN_W+1:0] head;
    logic [1:0]       head_op;
    logic [LEN_W-1:0] head_len;
    logic [LEN_W-1:0] head_len_eff;
    logic             mismatch;

    // Ready depends only on registered occupancy, so a same-cycle pop never
    // opens a slot for a push and nothing passes straight through.
    assign cmd_ready    = (level_q != FULL_LVL);
    assign push         = cmd_valid && cmd_ready;
    assign pop          = (state_q == ST_IDLE) && (level_q != '0);
    assign head         = mem_q[rd_ptr_q];
    assign head_op      = head[LEN_W+1:LEN_W];
    assign head_len     = head[LEN_W-1:0];
    assign head_len_eff = (head_len == '0) ? LEN_W'(1) : head_len;
    assign mismatch     = (state_q == ST_SETTLE) && (q != exp_q);

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push && pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_len};
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            exp_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        cnt_q   <= head_len_eff;
                        state_q <= ST_DRIVE;
                        case (head_op)
                            OP_SET: begin
                                s_q   <= 1'b1;
                                exp_q <= 1'b1;
                            end
                            OP_RESET: begin
                                r_q   <= 1'b1;
                                exp_q <= 1'b0;
                            end
                            OP_TOGGLE: begin
                                s_q   <= ~q;
                                r_q   <= q;
                                exp_q <= ~q;
                            end
                            default: begin
                                exp_q <= q;
                            end
                        endcase
                    end
                end
                ST_DRIVE: begin
                    cnt_q <= cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        s_q     <= 1'b0;
                        r_q     <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // A clear wins over a mismatch detected in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (mismatch) begin
            err_q     <= 1'b1;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign s       = s_q;
    assign r       = r_q;
    assign done    = done_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign level   = level_q;
    assign busy    = (state_q != ST_IDLE) || (level_q != '0);

endmodule
